fetch_module: RTL
=================

FETCH_MODULE -- requirements
Module: fetch_module

Interface
REQ-001 Parameter NB_BITS, default `NB_BITS (32), datapath/instruction width.
REQ-002 Parameter NB_JMP, default `NB_JUMP (28), jump target field width.
REQ-003 Parameter NB_ADDR, default 10, instruction memory word-address width (1024 words).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 o_if_id_pc  out  NB_BITS  IF/ID latched PC+4 of the fetched instruction.
REQ-008 o_if_id_instr  out  NB_BITS  IF/ID latched instruction word.
REQ-009 o_pc  out  NB_BITS  current PC register (debug).
REQ-010 o_halt  out  1  high while in HALT state.
REQ-011 i_brh_addr  in  NB_BITS  branch target from decode.
REQ-012 i_jmp_addr  in  NB_JMP  jump target low bits from decode, already word-shifted.
REQ-013 i_pc_beq  in  1  taken branch from decode.
REQ-014 i_pc_src  in  1  jump/JR/JAL/JALR from decode.
REQ-015 i_flush  in  1  replace next IF/ID instruction with NOP.
REQ-016 i_stall  in  1  hazard unit stall; freeze PC and IF/ID.
REQ-017 i_start  in  1  leave IDLE and begin fetching.
REQ-018 i_prog_wenb, i_prog_addr (NB_ADDR), i_prog_data (NB_BITS)  in  instruction memory load port.

Function
REQ-019 States: IDLE, RUN, HALT; encoding 2 bits.
REQ-020 IDLE: PC, IF/ID hold; IF/ID instr = 0 (NOP); i_prog_wenb writes i_prog_data at i_prog_addr next edge.
REQ-021 i_prog_wenb ignored outside IDLE.
REQ-022 IDLE -> RUN on i_start; first fetch at PC 0 in the first RUN cycle.
REQ-023 Instruction read combinational from imem at PC[NB_ADDR+1:2]; PC bits [1:0] always 0.
REQ-024 RUN, no stall: IF/ID <= {PC+4, imem[PC]} each edge; fetch-to-IF/ID latency 1 cycle.
REQ-025 Next-PC priority: i_pc_src -> {PC+4[NB_BITS-1:NB_JMP], i_jmp_addr}; else i_pc_beq -> i_brh_addr; else PC+4.
REQ-026 Instruction fetched in the redirect cycle is latched into IF/ID (branch delay slot) unless i_flush.
REQ-027 i_flush high (not stalled): IF/ID instr <= 0, IF/ID pc <= PC+4; PC updates per REQ-025.
REQ-028 i_stall high: PC and IF/ID hold; i_pc_src, i_pc_beq, i_flush ignored that cycle.
REQ-029 PC+4 wraps modulo 2^NB_BITS; imem address wraps modulo 2^NB_ADDR.
REQ-030 Fetched opcode [31:26] == `OP_INSTR_HALT (not stalled): instruction latched into IF/ID, PC frozen, RUN -> HALT.
REQ-031 HALT: PC frozen, IF/ID instr <= 0 every cycle (pipeline drains), o_halt = 1; exit only by reset.
REQ-032 Stall and HALT opcode simultaneously: stall wins, transition deferred.

Reset
REQ-033 i_rst: state IDLE, PC 0, o_if_id_pc 0, o_if_id_instr 0, o_halt 0; overrides all inputs, including mid-RUN.
REQ-034 Imem contents not cleared by reset.

Structure
REQ-035 State encodings, NOP value, and HALT opcode reside in the shared include file, alongside existing `OP_INSTR_* and `NB_* constants.
REQ-036 One sub-module, instr_memory: single write port, combinational read, 2^NB_ADDR x NB_BITS.

Verification
REQ-037 Load 0x20010005 at 0, 0x20020007 at 1, i_start -> IF/ID: (4, 0x20010005) then (8, 0x20020007).
REQ-038 i_pc_src with PC=0x10, i_jmp_addr=0x0000040 -> delay slot at 0x10 latched; next PC 0x40.
REQ-039 i_pc_beq with i_brh_addr=0x24, i_flush=1 -> IF/ID instr 0, pc 0x14 (PC was 0x10); next PC 0x24.
REQ-040 i_stall 2 cycles at PC=0x08 with i_pc_beq=1 -> PC, IF/ID unchanged; resume at 0x0C.
REQ-041 HALT at word 3 -> IF/ID holds HALT with pc 0x10; o_halt 1 next cycle; PC stays 0x0C; IF/ID instr 0 thereafter.
REQ-042 i_rst during RUN at PC=0x30 -> IDLE, all outputs 0; imem contents retained; i_prog_wenb in RUN has no effect.

Source files
------------

// File: rtl/fetch_module_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the state encoding, NOP word, HALT opcode and default widths.
package fetch_module_pkg;

   localparam int unsigned NB_WORD   = 32;
   localparam int unsigned NB_JUMP   = 28;
   localparam int unsigned NB_OPCODE = 6;

   localparam logic [NB_OPCODE-1:0] OP_INSTR_HALT = 6'b111111;
   localparam logic [NB_WORD-1:0]   INSTR_NOP     = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHalt = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/fetch_module_instr_memory.sv
// Instruction memory: one synchronous write port and a combinational read port.
// Contents are intentionally not reset, so a loaded program survives a core reset.
module instr_memory #(
   parameter int unsigned NB_BITS = 32,
   parameter int unsigned NB_ADDR = 10
) (
   input  logic               i_clk,
   input  logic               i_wenb,
   input  logic [NB_ADDR-1:0] i_waddr,
   input  logic [NB_BITS-1:0] i_wdata,
   input  logic [NB_ADDR-1:0] i_raddr,
   output logic [NB_BITS-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** NB_ADDR;

   logic [NB_BITS-1:0] mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wenb) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fetch_module.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID latch and
// IDLE/RUN/HALT control, with a program-load port usable only while idle.
module fetch_module
   import fetch_module_pkg::*;
#(
   parameter int unsigned NB_BITS = NB_WORD,
   parameter int unsigned NB_JMP  = NB_JUMP,
   parameter int unsigned NB_ADDR = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic [NB_BITS-1:0] o_if_id_pc,
   output logic [NB_BITS-1:0] o_if_id_instr,
   output logic [NB_BITS-1:0] o_pc,
   output logic               o_halt,
   input  logic [NB_BITS-1:0] i_brh_addr,
   input  logic [NB_JMP-1:0]  i_jmp_addr,
   input  logic               i_pc_beq,
   input  logic               i_pc_src,
   input  logic               i_flush,
   input  logic               i_stall,
   input  logic               i_start,
   input  logic               i_prog_wenb,
   input  logic [NB_ADDR-1:0] i_prog_addr,
   input  logic [NB_BITS-1:0] i_prog_data
);

   localparam logic [NB_BITS-1:0] NOP_WORD = NB_BITS'(INSTR_NOP);

   fetch_state_e       state_q, state_d;
   logic [NB_BITS-1:0] pc_q, pc_d;
   logic [NB_BITS-1:0] if_id_pc_q, if_id_pc_d;
   logic [NB_BITS-1:0] if_id_instr_q, if_id_instr_d;
   logic               halt_q, halt_d;

   logic [NB_BITS-1:0] instr;
   logic [NB_BITS-1:0] pc_plus4;
   logic [NB_BITS-1:0] redirect_pc;
   logic               mem_wenb;
   logic               fetch_halt;

   assign pc_plus4 = pc_q + NB_BITS'(4);
   assign mem_wenb = i_prog_wenb && (state_q == StIdle);

   instr_memory #(
      .NB_BITS (NB_BITS),
      .NB_ADDR (NB_ADDR)
   ) u_instr_memory (
      .i_clk   (i_clk),
      .i_wenb  (mem_wenb),
      .i_waddr (i_prog_addr),
      .i_wdata (i_prog_data),
      .i_raddr (pc_q[NB_ADDR+1:2]),
      .o_rdata (instr)
   );

   // A flushed HALT word is discarded, so it must not stop the core.
   assign fetch_halt = (instr[NB_BITS-1 -: NB_OPCODE] == OP_INSTR_HALT) && !i_flush;

   always_comb begin
      if (i_pc_src) begin
         redirect_pc = {pc_plus4[NB_BITS-1:NB_JMP], i_jmp_addr};
      end else if (i_pc_beq) begin
         redirect_pc = i_brh_addr;
      end else begin
         redirect_pc = pc_plus4;
      end
      redirect_pc[1:0] = 2'b00;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      halt_d        = halt_q;
      unique case (state_q)
         StIdle: begin
            if_id_instr_d = NOP_WORD;
            if (i_start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!i_stall) begin
               if_id_pc_d = pc_plus4;
               if (fetch_halt) begin
                  if_id_instr_d = instr;
                  state_d       = StHalt;
                  halt_d        = 1'b1;
               end else begin
                  if_id_instr_d = i_flush ? NOP_WORD : instr;
                  pc_d          = redirect_pc;
               end
            end
         end
         StHalt: begin
            if_id_instr_d = NOP_WORD;
         end
         default: begin
            state_d = StIdle;
            halt_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= StIdle;
         pc_q          <= '0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_WORD;
         halt_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         halt_q        <= halt_d;
      end
   end

   assign o_pc          = pc_q;
   assign o_if_id_pc    = if_id_pc_q;
   assign o_if_id_instr = if_id_instr_q;
   assign o_halt        = halt_q;

endmodule
